// File: rtl/aes_pkg.sv
// Shared AES-128 constants, state type and the linear round helpers
// (xtime, per-column MixColumns, ShiftRows).
package aes_pkg;

    localparam int unsigned AES_NR        = 10;
    localparam int unsigned AES_DCNT_LOAD = 11;
    localparam int unsigned AES_DCNT_W    = 4;

    typedef logic [127:0] aes_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte index b = row + 4*col sits at [127-8b -: 8]; row r rotates left by r columns.
    function automatic aes_state_t shift_rows(input aes_state_t s);
        aes_state_t o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * ((c + r) % 4)) -: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational table lookup.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] d_c
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign d_c = SBOX[a];

endmodule

// File: rtl/aes_cipher_round_engine.sv
// Iterative AES-128 encryption datapath, one round per clock, fed by an external key expander.
// Optional build macro AES_CIPHER_RESTART_EN: ld while busy restarts the engine with the new block.
module aes_cipher_round_engine
    import aes_pkg::*;
#(
    parameter int unsigned NR = AES_NR
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld,
    input  logic [127:0]  text_in,
    output logic          kld,
    input  logic [31:0]   wo_0,
    input  logic [31:0]   wo_1,
    input  logic [31:0]   wo_2,
    input  logic [31:0]   wo_3,
    output logic          busy,
    output logic          done,
    output logic [127:0]  text_out
);

    logic [AES_DCNT_W-1:0] dcnt_q, dcnt_d;
    aes_state_t            sa_q, sa_d;
    aes_state_t            text_in_r_q, text_in_r_d;
    aes_state_t            text_out_q, text_out_d;
    logic                  done_q, done_d;

    aes_state_t rk, sb, sr, mc;
    logic       accept_c;

    assign rk = {wo_0, wo_1, wo_2, wo_3};

    // SubBytes on the current state, then the linear layers.
    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_sbox u_sbox (
            .a   (sa_q[127 - 8 * i -: 8]),
            .d_c (sb[127 - 8 * i -: 8])
        );
    end

    assign sr = shift_rows(sb);

    for (genvar c = 0; c < 4; c++) begin : g_mix
        assign mc[127 - 32 * c -: 32] = mix_col(sr[127 - 32 * c -: 32]);
    end

    assign busy = (dcnt_q != '0);

`ifdef AES_CIPHER_RESTART_EN
    assign accept_c = ld;
`else
    assign accept_c = ld & ~busy;
`endif

    assign kld = accept_c;

    // A load always wins; a restarted in-flight block is simply dropped.
    always_comb begin
        dcnt_d      = dcnt_q;
        sa_d        = sa_q;
        text_in_r_d = text_in_r_q;
        text_out_d  = text_out_q;
        done_d      = 1'b0;
        if (accept_c) begin
            text_in_r_d = text_in;
            dcnt_d      = AES_DCNT_W'(AES_DCNT_LOAD);
        end else if (busy) begin
            dcnt_d = dcnt_q - AES_DCNT_W'(1);
            if (dcnt_q == AES_DCNT_W'(AES_DCNT_LOAD)) begin
                sa_d = text_in_r_q ^ rk;
            end else if (dcnt_q == AES_DCNT_W'(1)) begin
                text_out_d = sr ^ rk;
                done_d     = 1'b1;
            end else begin
                sa_d = mc ^ rk;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_q      <= '0;
            sa_q        <= '0;
            text_in_r_q <= '0;
            text_out_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            dcnt_q      <= dcnt_d;
            sa_q        <= sa_d;
            text_in_r_q <= text_in_r_d;
            text_out_q  <= text_out_d;
            done_q      <= done_d;
        end
    end

    assign done     = done_q;
    assign text_out = text_out_q;

    a_dcnt_range: assert property (@(posedge clk) disable iff (!rst_n)
        dcnt_q <= AES_DCNT_W'(NR + 1));

endmodule

// File: tb/tb_aes_cipher_round_engine.sv
// Directed bench for aes_cipher_round_engine with a behavioural key expander.
module tb_aes_cipher_round_engine;

    logic         clk;
    logic         rst_n;
    logic         ld;
    logic [127:0] text_in;
    logic         kld;
    logic [31:0]  wo_0, wo_1, wo_2, wo_3;
    logic         busy;
    logic         done;
    logic [127:0] text_out;

    logic [127:0] key_in;
    logic [127:0] ek;
    logic [7:0]   rcon;

    int n_chk  = 0;
    int n_fail = 0;

    aes_cipher_round_engine dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld       (ld),
        .text_in  (text_in),
        .kld      (kld),
        .wo_0     (wo_0),
        .wo_1     (wo_1),
        .wo_2     (wo_2),
        .wo_3     (wo_3),
        .busy     (busy),
        .done     (done),
        .text_out (text_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // S-box derived from the GF(2^8) inverse plus the affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_f(input logic [7:0] x);
        logic [7:0]  y = 8'h00;
        logic [15:0] yy;
        for (int i = 1; i < 256; i++) begin
            if (gmul(x, 8'(i)) == 8'h01) y = 8'(i);
        end
        yy = {y, y};
        return y ^ yy[14:7] ^ yy[13:6] ^ yy[12:5] ^ yy[11:4] ^ 8'h63;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
        t  = {sbox_f(w3[23:16]) ^ rc, sbox_f(w3[15:8]), sbox_f(w3[7:0]), sbox_f(w3[31:24])};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Key expander: loads on kld, otherwise advances one round key per clock.
    always @(posedge clk) begin
        if (kld) begin
            ek   <= key_in;
            rcon <= 8'h01;
        end else begin
            ek   <= next_key(ek, rcon);
            rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        end
    end

    assign wo_0 = ek[127:96];
    assign wo_1 = ek[95:64];
    assign wo_2 = ek[63:32];
    assign wo_3 = ek[31:0];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Present a load at the current (negedge) time, then release it after the edge.
    task automatic start(input logic [127:0] k, input logic [127:0] pt, input logic exp_kld, input string nm);
        key_in  = k;
        text_in = pt;
        ld      = 1'b1;
        #1;
        check({nm, " kld"}, 128'(kld), 128'(exp_kld));
        @(posedge clk);
        #1;
        ld = 1'b0;
    endtask

    // Wait for done; returns at the negedge where done is seen.
    task automatic wait_done(input int exp_lat, input logic [127:0] exp_ct, input string nm);
        int   n   = 0;
        logic got = 1'b0;
        logic bok = 1'b1;
        while (!got && n < 30) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) got = 1'b1;
            else if (!busy && n < exp_lat) bok = 1'b0;
        end
        check({nm, " latency"}, 128'(n), 128'(exp_lat));
        check({nm, " ct"}, text_out, exp_ct);
        check({nm, " busy held"}, 128'(bok), 128'(1));
    endtask

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        string        name;
    } vec_t;

    vec_t vecs [3];

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    initial begin
        logic [127:0] last;
        logic         ok_kld, ok_done, ok_hold;

        vecs[0] = '{KEY_B, PT_B, CT_B, "fips_b"};
        vecs[1] = '{KEY_C, PT_C, CT_C, "fips_c1"};
        vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, "zero"};

        rst_n   = 1'b0;
        ld      = 1'b0;
        text_in = '0;
        key_in  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", 128'(busy), 128'(0));
        check("reset done", 128'(done), 128'(0));
        check("reset text_out", text_out, 128'h0);
        check("reset kld", 128'(kld), 128'(0));
        rst_n = 1'b1;

        // Table-driven single blocks.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start(vecs[i].key, vecs[i].pt, 1'b1, vecs[i].name);
            wait_done(11, vecs[i].ct, vecs[i].name);
            @(negedge clk);
            check({vecs[i].name, " done pulse"}, 128'(done), 128'(0));
        end

        // Back-to-back: second load in the done cycle of the first.
        @(negedge clk);
        start(KEY_B, PT_B, 1'b1, "b2b first");
        wait_done(11, CT_B, "b2b first");
        start(KEY_C, PT_C, 1'b1, "b2b second");
        wait_done(11, CT_C, "b2b second");

        // Load arriving in cycle 5 of a block.
        @(negedge clk);
        start(KEY_B, PT_B, 1'b1, "mid first");
        repeat (4) @(posedge clk);
        @(negedge clk);
        last = text_out;
`ifdef AES_CIPHER_RESTART_EN
        start(KEY_C, PT_C, 1'b1, "mid restart");
        check("mid text_out held", text_out, last);
        wait_done(11, CT_C, "mid restart");
`else
        start(KEY_C, PT_C, 1'b0, "mid ignored");
        wait_done(6, CT_B, "mid ignored");
`endif

        // Asynchronous reset mid-block, then a fresh block.
        @(negedge clk);
        start(KEY_B, PT_B, 1'b1, "rst first");
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst busy", 128'(busy), 128'(0));
        check("async rst done", 128'(done), 128'(0));
        check("async rst text_out", text_out, 128'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start(KEY_B, PT_B, 1'b1, "after rst");
        wait_done(11, CT_B, "after rst");

        // Idle hold for 50 cycles.
        last    = text_out;
        ok_kld  = 1'b1;
        ok_done = 1'b1;
        ok_hold = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (kld) ok_kld = 1'b0;
            if (i > 0 && done) ok_done = 1'b0;
            if (text_out !== last) ok_hold = 1'b0;
        end
        check("idle kld", 128'(ok_kld), 128'(1));
        check("idle done", 128'(ok_done), 128'(1));
        check("idle text_out hold", text_out, CT_B);
        check("idle text_out stable", 128'(ok_hold), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
